// File: rtl/mach_dem_xuong_4bit.sv
`default_nettype none
// ============================================================================
// Module   : mach_dem_xuong_4bit
// Purpose  : Loadable down counter with terminal-count pulse and either
//            one-shot or periodic (auto-reload) operation.
// Revision : 1.0 - initial release
// ============================================================================
module mach_dem_xuong_4bit #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = 4'hF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             start,
    input  logic             en,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_reload;
    logic             r_tc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_q      <= RESET_VALUE;
            r_reload <= RESET_VALUE;
            r_tc     <= 1'b0;
        end else begin
            // tc is a single-cycle pulse; only the 1->0 step re-arms it
            r_tc <= 1'b0;
            if (load) begin
                r_q      <= din;
                r_reload <= din;
                r_state  <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            if (r_q == c_zero) begin
                                if (r_reload == c_zero) begin
                                    r_state <= S_DONE;
                                end else begin
                                    r_q     <= r_reload;
                                    r_state <= S_RUN;
                                end
                            end else begin
                                r_state <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        if (en) begin
                            if (r_q == c_zero) begin
                                // wrap after the terminal cycle of a periodic run
                                if (r_reload == c_zero) begin
                                    r_state <= S_DONE;
                                end else begin
                                    r_q <= r_reload;
                                end
                            end else if (r_q == c_one) begin
                                r_q  <= c_zero;
                                r_tc <= 1'b1;
                                if (!auto_reload) begin
                                    r_state <= S_DONE;
                                end
                            end else begin
                                r_q <= r_q - c_one;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign q    = r_q;
    assign tc   = r_tc;
    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mach_dem_xuong_4bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mach_dem_xuong_4bit
// Purpose  : Directed self-checking bench for the loadable down counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mach_dem_xuong_4bit;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] din;
    logic       start;
    logic       en;
    logic       auto_reload;
    logic [3:0] q;
    logic       tc;
    logic       busy;
    logic       done;

    int checks;
    int errors;

    mach_dem_xuong_4bit #(
        .WIDTH       (4),
        .RESET_VALUE (4'hF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .din         (din),
        .start       (start),
        .en          (en),
        .auto_reload (auto_reload),
        .q           (q),
        .tc          (tc),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eq, input logic etc,
                           input logic ebusy, input logic edone);
        chk({tag, ".q"},    {4'h0, q},    {4'h0, eq});
        chk({tag, ".tc"},   {7'h0, tc},   {7'h0, etc});
        chk({tag, ".busy"}, {7'h0, busy}, {7'h0, ebusy});
        chk({tag, ".done"}, {7'h0, done}, {7'h0, edone});
    endtask

    initial begin
        logic [3:0] ev;
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        load        = 1'b0;
        din         = 4'h0;
        start       = 1'b0;
        en          = 1'b0;
        auto_reload = 1'b0;

        // reset state
        #12;
        chk_all("reset", 4'hF, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // one-shot from 15 down to 0
        en = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("os_start", 4'hF, 1'b0, 1'b1, 1'b0);
        for (int i = 14; i >= 1; i--) begin
            tick();
            chk_all("os_cnt", 4'(i), 1'b0, 1'b1, 1'b0);
        end
        tick();
        chk_all("os_term", 4'h0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_all("os_hold", 4'h0, 1'b0, 1'b0, 1'b1);
        end

        // periodic with reload 5: period of 6 clocks
        din = 4'h5;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk_all("p_load", 4'h5, 1'b0, 1'b0, 1'b0);
        auto_reload = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("p_start", 4'h5, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 13; k++) begin
            ev = 4'(5 - ((k + 1) % 6));
            tick();
            chk_all("p_cnt", ev, (ev == 4'h0), 1'b1, 1'b0);
        end

        // asynchronous reset mid-count at q=9
        auto_reload = 1'b0;
        din = 4'hA;
        load = 1'b1;
        tick();
        load = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("ar_start", 4'hA, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("ar_q9", 4'h9, 1'b0, 1'b1, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk_all("ar_async", 4'hF, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        tick();
        chk_all("ar_idle", 4'hF, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("ar_restart", 4'hF, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("ar_e", 4'hE, 1'b0, 1'b1, 1'b0);

        // run down to 7, pause, then load beats start
        for (int i = 0; i < 7; i++) tick();
        chk_all("pause_q7", 4'h7, 1'b0, 1'b1, 1'b0);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all("pause_hold", 4'h7, 1'b0, 1'b1, 1'b0);
        end
        din = 4'h3;
        load = 1'b1;
        start = 1'b1;
        tick();
        load = 1'b0;
        start = 1'b0;
        en = 1'b1;
        chk_all("ld_wins", 4'h3, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("idle_no_en", 4'h3, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("ld3_start", 4'h3, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("ld3_2", 4'h2, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("ld3_1", 4'h1, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("ld3_0", 4'h0, 1'b1, 1'b0, 1'b1);

        // zero reload goes straight to DONE with no tc
        din = 4'h0;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk_all("z_load", 4'h0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("z_start", 4'h0, 1'b0, 1'b0, 1'b1);
        din = 4'h2;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk_all("two_load", 4'h2, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("two_start", 4'h2, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("two_1", 4'h1, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("two_0", 4'h0, 1'b1, 1'b0, 1'b1);
        tick();
        chk_all("two_after", 4'h0, 1'b0, 1'b0, 1'b1);

        // restart from DONE reloads; auto_reload sampled at the 1->0 step
        din = 4'h4;
        load = 1'b1;
        tick();
        load = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk_all("d4_done", 4'h0, 1'b1, 1'b0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("d4_restart", 4'h4, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("d4_3", 4'h3, 1'b0, 1'b1, 1'b0);
        auto_reload = 1'b1;
        tick();
        chk_all("d4_2", 4'h2, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("d4_1", 4'h1, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("d4_0", 4'h0, 1'b1, 1'b1, 1'b0);
        tick();
        chk_all("d4_wrap", 4'h4, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("d4_wrap3", 4'h3, 1'b0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mach_dem_xuong_4bit.md
Name: mach_dem_xuong_4bit

Overview:
- 4-bit loadable down counter: the count-down counterpart of the team's 4-bit up counter.
- Counts from a programmable start value to 0, flags terminal count, then either stops (one-shot) or reloads (periodic).
- Serves as a timeout/period generator next to the up counter; the same bench style (free-running clk, reset pulses) drives it.

Parameters:
- WIDTH, 4, counter and data width.
- RESET_VALUE, 4'hF, value of q and of the reload register after reset.

Ports:
- clk  input  1  single system clock; all registers update on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  synchronous load strobe; highest priority.
- din  input  WIDTH  load value; captured into q and the reload register on load.
- start  input  1  single-cycle strobe; starts a run from IDLE or DONE.
- en  input  1  count enable; decrements only when high in RUN.
- auto_reload  input  1  1 = periodic (wrap to reload value); 0 = one-shot (stop at 0).
- q  output  WIDTH  current count.
- tc  output  1  terminal-count pulse, registered, exactly one clk wide.
- busy  output  1  high while state == RUN.
- done  output  1  high while state == DONE (level).

Behaviour:
- Reset (async, immediate, also mid-run): q=RESET_VALUE, reload=RESET_VALUE, state=IDLE, tc=0, busy=0, done=0.
- States: IDLE, RUN, DONE. busy and done are decoded from state, so they have no glitches relative to clk.
- Input priority per edge: load > start > en.
- load, any state:
  - q<=din, reload<=din, state<=IDLE.
  - tc<=0, done<=0.
  - An in-flight count is abandoned.
- start:
  - In IDLE or DONE: state<=RUN; if q==0 then q<=reload.
  - If q==0 and reload==0: state<=DONE instead; no tc.
  - In RUN: start is ignored.
- RUN with en=0: q holds; tc=0.
- RUN with en=1:
  - q>1: q<=q-1.
  - q==1: q<=0 and tc<=1 for the next cycle only. If auto_reload=1, stay in RUN; else state<=DONE.
  - q==0 (auto-reload wrap): q<=reload, stay in RUN, no tc. If reload==0: state<=DONE, no tc.
- Period with auto_reload=1 and en held high: reload+1 clocks per tc pulse, e.g. 15,14,…,0,15.
- auto_reload is sampled on the edge where q goes 1->0. Changing it at any other time has no effect on that cycle.
- DONE: q holds 0, done=1 until load or start. en is ignored.
- IDLE: q holds. en is ignored, so no count happens without start.
- tc is 0 on every cycle except the one following the 1->0 decrement, and is never asserted by load or reset.
- All arithmetic is unsigned modulo 2^WIDTH. q never underflows below 0, because the 0 case is handled explicitly.

Test Plan:
- Reset, then start with en=1 and auto_reload=0 -> q: 15,14,…,1,0. tc is high exactly one cycle (q==0 cycle). Then done=1 and busy=0; q stays 0 for 20 more clocks.
- load din=5, start, en=1, auto_reload=1 -> q: 5,4,3,2,1,0,5,4,… The tc pulse repeats every 6 clocks; busy stays 1.
- Mid-count (q=9) assert reset for 3 ns off-edge -> q=15 and IDLE immediately, before the next clk edge. Release, then start -> restarts at 15.
- During RUN at q=7: en low for 4 clocks -> q holds 7. Then load and start in the same cycle, din=3 -> q=3 and state IDLE, because load wins. A later start counts 3,2,1,0.
- load din=0 then start -> state DONE next cycle, done=1, no tc. Then load din=2 and start with auto_reload=0 -> 2,1,0, one tc, done=1.
- In DONE: start with reload=4 -> q=4 and RUN. Toggle auto_reload 0->1 while q=3 -> no effect until the sample at q==1 (then wraps to 4).
